// File: rtl/uart_pkg.sv
// Shared definitions for the host-side UART transmitter.
// Frame states, divider width and the autobaud sync character.
package uart_pkg;

  localparam int DIV_W = 11;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'h55;
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  function automatic logic [DIV_W-1:0] clamp_div(
    input logic [DIV_W-1:0] d
  );
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the transmitter.
// Pointers carry one extra MSB so full and empty are distinguishable.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             wdata,
  output logic [7:0]             rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [7:0] mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;

  assign level = wp - rp;
  assign full  = (level == CAP);
  assign empty = (wp == rp);
  assign rdata = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + ONE;
      if (pop && !empty)
        rp <= rp + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_host_tx.sv
// 8N1 UART transmitter with byte FIFO and autobaud sync character.
// Sync frames pre-empt queued data at every frame boundary.
module uart_host_tx
  import uart_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic [DIV_W-1:0]       div,
  input  logic                   sync_req,
  input  logic [7:0]             wdata,
  input  logic                   wvalid,
  output logic                   wready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   synced
);

  state_t state;
  state_t state_n;

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_l;
  logic [DIV_W-1:0] div_n;
  logic [2:0]       bitn;
  logic [9:0]       shreg;
  logic             sync_pend;
  logic             cur_sync;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [7:0]       rdata;
  logic             pending;
  logic             bit_end;
  logic             start_frame;

  assign push    = wvalid && !full;
  assign wready  = !full;
  assign pending = sync_pend || !empty;
  assign bit_end = (cnt == '0);
  assign busy    = (state != IDLE) || pending;
  assign div_n   = clamp_div(div);
  assign pop     = start_frame && !sync_pend;

  uart_tx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nreset(nreset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    state_n     = state;
    start_frame = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending) begin
          state_n     = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (bit_end)
          state_n = DATA;
      end
      DATA: begin
        if (bit_end && bitn == 3'd7)
          state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (pending) begin
            state_n     = START;
            start_frame = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // tx is always the next bit of the shift register, so it is a pure flop
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      cnt      <= '0;
      div_l    <= '0;
      bitn     <= '0;
      shreg    <= '1;
      tx       <= 1'b1;
      cur_sync <= 1'b0;
    end else begin
      state <= state_n;
      if (start_frame) begin
        div_l    <= div_n;
        cnt      <= div_n - DIV_ONE;
        bitn     <= '0;
        shreg    <= {1'b1, (sync_pend ? SYNC_BYTE : rdata), 1'b0};
        tx       <= 1'b0;
        cur_sync <= sync_pend;
      end else if (state != IDLE) begin
        if (bit_end) begin
          cnt   <= div_l - DIV_ONE;
          shreg <= {1'b1, shreg[9:1]};
          tx    <= shreg[1];
          if (state == DATA)
            bitn <= bitn + 3'd1;
        end else begin
          cnt <= cnt - DIV_ONE;
        end
      end
    end
  end

  // a re-arm during a sync frame keeps synced low until the extra frame ends
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_pend <= 1'b1;
      synced    <= 1'b0;
    end else begin
      if (sync_req)
        sync_pend <= 1'b1;
      else if (start_frame && sync_pend)
        sync_pend <= 1'b0;
      if (sync_req)
        synced <= 1'b0;
      else if (state == STOP && bit_end && cur_sync && !sync_pend)
        synced <= 1'b1;
    end
  end

endmodule
